// File: rtl/cfg_write_arbiter.sv
// cfg_write_arbiter: round-robin arbitration of two config writers into a 5-register bank; optional A-only lock at 0x05 via CFG_WRITE_ARBITER_LOCK_EN
module cfg_write_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       busy,
    output logic       err_pulse,
    output logic [7:0] wr_count
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, COMMIT} state_t;
    state_t     state;
    logic       last_b;
    logic       src_b;
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic       ok;
`ifdef CFG_WRITE_ARBITER_LOCK_EN
    logic       lock;
    assign ok = src_b ? (!lock && addr_q <= 7'd4) : (addr_q <= 7'd5);
`else
    assign ok = addr_q <= 7'd4;
`endif
    assign a_ready = state == GRANT_A;
    assign b_ready = state == GRANT_B;
    assign busy    = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last_b          <= 1'b1;
            src_b           <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            err_pulse       <= 1'b0;
            wr_count        <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
`ifdef CFG_WRITE_ARBITER_LOCK_EN
            lock            <= 1'b0;
`endif
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_valid && (!b_valid || last_b)) begin
                        state  <= GRANT_A;
                        last_b <= 1'b0;
                    end else if (b_valid) begin
                        state  <= GRANT_B;
                        last_b <= 1'b1;
                    end
                end
                GRANT_A: begin
                    state  <= a_valid ? COMMIT : IDLE;
                    addr_q <= a_addr;
                    data_q <= a_data;
                    src_b  <= 1'b0;
                end
                GRANT_B: begin
                    state  <= b_valid ? COMMIT : IDLE;
                    addr_q <= b_addr;
                    data_q <= b_data;
                    src_b  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    if (ok) begin
                        wr_count <= wr_count + 8'd1;
                        if (addr_q == 7'd0) en_reg_out_7_0  <= data_q;
                        if (addr_q == 7'd1) en_reg_out_15_8 <= data_q;
                        if (addr_q == 7'd2) en_reg_pwm_7_0  <= data_q;
                        if (addr_q == 7'd3) en_reg_pwm_15_8 <= data_q;
                        if (addr_q == 7'd4) pwm_duty_cycle  <= data_q;
`ifdef CFG_WRITE_ARBITER_LOCK_EN
                        if (addr_q == 7'd5) lock <= data_q[0];
`endif
                    end else begin
                        err_pulse <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb_cfg_write_arbiter: randomized rounds against a transaction-level model of the config bank.
module tb_cfg_write_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [6:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, busy, err_pulse;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, wr_count;

    cfg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .busy(busy), .err_pulse(err_pulse),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    logic [7:0] m_reg [0:4];
    bit   m_lock, m_last_b;
    int   m_cnt, m_err = 0, seen_err = 0;

    always @(negedge clk) if (err_pulse) seen_err++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ok(input bit sb, input logic [6:0] ad);
`ifdef CFG_WRITE_ARBITER_LOCK_EN
        return sb ? (!m_lock && ad <= 4) : (ad <= 5);
`else
        return ad <= 4;
`endif
    endfunction

    function automatic void m_apply(input bit sb, input logic [6:0] ad, input logic [7:0] d);
        if (m_ok(sb, ad)) begin
            if (ad < 5) m_reg[ad] = d;
            else m_lock = d[0];
            m_cnt = (m_cnt + 1) % 256;
        end else m_err++;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        m_cnt = 0;
        m_lock = 0;
        m_last_b = 1;
    endfunction

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return en_reg_out_7_0;
            1: return en_reg_out_15_8;
            2: return en_reg_pwm_7_0;
            3: return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < 5; i++) check($sformatf("%s reg%0d", tag, i), dut_reg(i), m_reg[i]);
        check({tag, " wr_count"}, wr_count, m_cnt);
        check({tag, " err_count"}, seen_err, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        a_valid = 0;
        b_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        m_reset();
    endtask

    task automatic run_round(input string tag, input bit ua, input bit ub,
                             input logic [6:0] aa, input logic [7:0] ad,
                             input logic [6:0] ba, input logic [7:0] bd);
        bit a_drop = 0, b_drop = 0;
        int exp_first, first_g = -1, a_rdy = 0, b_rdy = 0;
        exp_first = (ua && ub) ? (m_last_b ? 0 : 1) : (ua ? 0 : 1);
        if (ua && ub) begin
            if (exp_first == 0) begin m_apply(0, aa, ad); m_apply(1, ba, bd); end
            else begin m_apply(1, ba, bd); m_apply(0, aa, ad); end
            m_last_b = exp_first == 0;
        end else begin
            if (ua) m_apply(0, aa, ad);
            else m_apply(1, ba, bd);
            m_last_b = ub;
        end
        @(negedge clk);
        a_valid = ua; a_addr = aa; a_data = ad;
        b_valid = ub; b_addr = ba; b_data = bd;
        for (int c = 0; c < 40 && (a_valid || b_valid); c++) begin
            @(negedge clk);
            if (a_drop) begin a_valid = 0; a_drop = 0; end
            if (b_drop) begin b_valid = 0; b_drop = 0; end
            if (a_ready) begin a_drop = 1; a_rdy++; if (first_g < 0) first_g = 0; end
            if (b_ready) begin b_drop = 1; b_rdy++; if (first_g < 0) first_g = 1; end
        end
        check({tag, " timeout"}, a_valid | b_valid, 0);
        a_valid = 0;
        b_valid = 0;
        repeat (3) @(negedge clk);
        check({tag, " first grant"}, first_g, exp_first);
        check({tag, " a_ready cycles"}, a_rdy, ua);
        check({tag, " b_ready cycles"}, b_rdy, ub);
        check_state(tag);
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset a_ready", a_ready, 0);
        check("reset b_ready", b_ready, 0);
        check("reset busy", busy, 0);
        check("reset err", err_pulse, 0);
        rst = 0;

        // single A write, cycle-exact latency
        @(negedge clk);
        a_valid = 1; a_addr = 7'h04; a_data = 8'h80;
        @(negedge clk);
        check("lat a_ready", a_ready, 1);
        check("lat busy", busy, 1);
        @(negedge clk);
        check("lat a_ready drop", a_ready, 0);
        check("lat pwm early", pwm_duty_cycle, 8'h00);
        a_valid = 0;
        @(negedge clk);
        check("lat pwm", pwm_duty_cycle, 8'h80);
        check("lat wr_count", wr_count, 1);
        m_apply(0, 7'h04, 8'h80);
        m_last_b = 0;
        repeat (2) @(negedge clk);
        check_state("lat");

        do_reset();
        run_round("tie", 1, 1, 7'h00, 8'h11, 7'h01, 8'h22);
        check("tie out_7_0", en_reg_out_7_0, 8'h11);
        check("tie out_15_8", en_reg_out_15_8, 8'h22);
        check("tie wr_count", wr_count, 2);

        run_round("bad addr", 0, 1, 7'h00, 8'h00, 7'h07, 8'hFF);

        // A withdraws while granted
        @(negedge clk);
        a_valid = 1; a_addr = 7'h01; a_data = 8'h33;
        @(negedge clk);
        check("withdraw a_ready", a_ready, 1);
        a_valid = 0;
        @(negedge clk);
        check("withdraw busy", busy, 0);
        repeat (2) @(negedge clk);
        m_last_b = 0;
        check_state("withdraw");

        // reset while committing
        @(negedge clk);
        a_valid = 1; a_addr = 7'h02; a_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        check("rst commit busy", busy, 1);
        rst = 1;
        a_valid = 0;
        @(negedge clk);
        rst = 0;
        m_reset();
        check("rst commit pwm_7_0", en_reg_pwm_7_0, 8'h00);
        check("rst commit busy after", busy, 0);
        check_state("rst commit");

        for (int i = 0; i < 256; i++)
            run_round("wrap", 1, 0, 7'($urandom_range(0, 4)), 8'($urandom), 7'h00, 8'h00);
        check("wrap wr_count", wr_count, 0);

`ifdef CFG_WRITE_ARBITER_LOCK_EN
        run_round("lock set", 1, 0, 7'h05, 8'h01, 7'h00, 8'h00);
        run_round("lock b", 0, 1, 7'h00, 8'h00, 7'h00, 8'hAA);
        run_round("lock a", 1, 0, 7'h03, 8'h5A, 7'h00, 8'h00);
        run_round("lock clr", 1, 0, 7'h05, 8'h00, 7'h00, 8'h00);
`endif

        for (int i = 0; i < 150; i++) begin
            bit ua, ub;
            logic [6:0] aa, ba;
            ua = 1'($urandom);
            ub = ua ? 1'($urandom) : 1'b1;
            aa = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
            ba = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
            run_round($sformatf("rand%0d", i), ua, ub, aa, 8'($urandom), ba, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfg_write_arbiter.md
CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have ports a_valid (input, 1), a_addr (input, 7), a_data (input, 8), a_ready (output, 1) for requester A, the serial-interface decoder.
REQ-004 SHALL have ports b_valid (input, 1), b_addr (input, 7), b_data (input, 8), b_ready (output, 1) for requester B, the on-chip sequencer.
REQ-005 SHALL have outputs en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each 8 bits, forming the configuration bank at addresses 0x00-0x04.
REQ-006 SHALL have output busy (1): state is not IDLE.
REQ-007 SHALL have output err_pulse (1): one-cycle flag for a rejected write.
REQ-008 SHALL have output wr_count (8): count of committed writes.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT_A, GRANT_B and COMMIT.
REQ-010 SHALL, in IDLE with exactly one valid high, move to that requester's GRANT state next cycle.
REQ-011 SHALL, in IDLE with both valid high, grant the requester not granted last (round robin); last_grant SHALL be updated on the transition.
REQ-012 SHALL drive a_ready high only in GRANT_A, and b_ready high only in GRANT_B, both as registered state decodes.
REQ-013 SHALL, in GRANT_x with x_valid high, capture x_addr/x_data and the source ID, then go to COMMIT.
REQ-014 SHALL, in GRANT_x with x_valid low (requester withdrew), return to IDLE with no write, no err and no count.
REQ-015 SHALL, in COMMIT, write captured data to the register at captured address if address <= 0x04, then return to IDLE.
REQ-016 SHALL make the register update visible on the cycle after COMMIT; latency from valid seen in IDLE to output update SHALL be 3 cycles.
REQ-017 SHALL make sustained throughput one write per 3 cycles; no request SHALL be accepted outside GRANT states.
REQ-018 SHALL, for a captured address > 0x04 (or rejected per REQ-025), make no register change and assert err_pulse for exactly the cycle after COMMIT.
REQ-019 SHALL increment wr_count on each committed register write only, wrapping 0xFF -> 0x00.
REQ-020 SHALL never expose partial writes; all eight bits of the target update together.
REQ-021 SHALL leave unaddressed registers unchanged.
REQ-022 SHALL require requesters to hold valid/addr/data stable until ready; behaviour is otherwise defined only per REQ-014.

Reset
REQ-023 SHALL, with rst high on any edge and in any state, force IDLE, all five registers 0x00, wr_count 0x00, a_ready/b_ready/busy/err_pulse 0 and last_grant = B (A wins first tie); any in-flight transaction SHALL be dropped without a write.

Configuration
REQ-024 SHALL, with macro CFG_WRITE_ARBITER_LOCK_EN defined, add a lock register at 0x05 bit0, reset 0 and writable only by A; writes to 0x05 SHALL count in wr_count.
REQ-025 SHALL, with CFG_WRITE_ARBITER_LOCK_EN defined and lock=1, reject B writes to any address (err_pulse, no change, no count); A SHALL be unaffected.
REQ-026 SHALL, without CFG_WRITE_ARBITER_LOCK_EN, have no lock register and treat 0x05 as invalid per REQ-018.

Verification
REQ-027 SHALL cover: after reset, A writes 0x04<-0x80 -> a_ready high 1 cycle, pwm_duty_cycle=0x80 3 cycles after valid, wr_count=1.
REQ-028 SHALL cover: A and B valid same cycle (A:0x00<-0x11, B:0x01<-0x22) -> A granted first, B next, en_reg_out_7_0=0x11, en_reg_out_15_8=0x22, wr_count=2.
REQ-029 SHALL cover: B writes 0x07<-0xFF -> err_pulse one cycle, all registers unchanged, wr_count unchanged.
REQ-030 SHALL cover: A asserts valid then drops it during GRANT_A -> return to IDLE, no write, no err.
REQ-031 SHALL cover: rst asserted during COMMIT of 0x02<-0x55 -> en_reg_pwm_7_0=0x00, IDLE next cycle; and 256 writes -> wr_count wraps to 0x00.
REQ-032 SHALL cover, with CFG_WRITE_ARBITER_LOCK_EN defined: A writes 0x05<-0x01, then B writes 0x00<-0xAA -> err_pulse, en_reg_out_7_0 unchanged.
